regwrite_scheduler: RTL and testbench
=====================================

# regwrite_scheduler

Arbitrates the decode-stage register file's single write port between pipeline writeback (WB) and a multi-cycle multiply/divide unit (MD). Buffers MD results in a small FIFO and tracks pending MD destination registers in a scoreboard. Stalls decode on read-after-write and write-after-write hazards against pending registers. Sits between the WB stage, the MD unit and `reg_file` in the decode stage.

## Interface
Parameters:
- `FIFO_DEPTH`, 2: MD result buffer entries (power of two, ≥2).
- `STARVE_LIMIT`, 4: consecutive WB grants allowed while FIFO non-empty before FIFO is forced.

Ports (one clock; reset is synchronous and active-high):
- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `wb_write` in 1: WB requests a register write.
- `wb_reg_id` in 5, `wb_data` in 32: WB destination and value.
- `md_valid` in 1: MD result available.
- `md_ready` out 1: FIFO can accept; push = `md_valid & md_ready`.
- `md_reg_id` in 5, `md_data` in 32: MD destination and value.
- `issue_md` in 1, `issue_reg_id` in 5: decode issues an MD op targeting `issue_reg_id`.
- `rs_id` in 5, `rt_id` in 5, `rd_id` in 5: decode sources and destination for hazard check.
- `stall` out 1: decode must hold.
- `wb_stall` out 1: pipeline must hold WB contents this cycle.
- `rf_write` out 1, `rf_write_id` out 5, `rf_write_data` out 32: registered drive of `reg_file` write port.

## Operation
- Grant per cycle:
  - If `wb_stall`, FIFO head wins and `wb_write` is ignored.
  - Else if `wb_write`, WB wins.
  - Else if FIFO is non-empty, FIFO head wins.
  - Else no write.
- A granted write loads the `rf_*` registers next edge. A FIFO grant pops the head.
- Writes with id 0 are dropped: `rf_write` stays 0, but a FIFO grant still pops and clears nothing.
- `md_ready` = count < `FIFO_DEPTH`; forced 0 while `reset`. There is no bypass: a push into an empty FIFO is first grantable the following cycle. Push and pop in the same cycle are legal at any occupancy, including full, where `md_ready` is 0 so no push occurs.
- Scoreboard `pending[31:1]`:
  - Set on `issue_md` with nonzero id.
  - Cleared when that register's FIFO entry is granted.
  - Set and clear of different registers in the same cycle both apply.
  - `issue_md` to an already-pending register is illegal; `stall` prevents it.
- `stall` = `pending[rs_id] | pending[rt_id] | pending[rd_id]`, with id 0 never pending. Combinational from registered state; 0 during reset.
- Starvation counter:
  - Increments on each WB grant while the FIFO is non-empty.
  - Clears on any FIFO grant or when the FIFO is empty.
  - `wb_stall` = (counter == `STARVE_LIMIT`).
- Reset values: `rf_write`=0, `rf_write_id`=0, `rf_write_data`=0, FIFO empty, pending all 0, counter 0, `stall`=0, `wb_stall`=0. Reset mid-operation discards buffered MD results.

## Timing
- Write latency: granted request at edge N appears on `rf_*` after edge N; `reg_file` commits at edge N+1.
- MD latency, uncontended: push at edge N, grant in cycle N+1, `rf_write` after edge N+1.
- `stall` deasserts the cycle after the clearing FIFO grant edge.
- During a `wb_stall` cycle, WB presents the same write again the next cycle. That write is then granted, since the counter has cleared.

## Structure
- Shared package `mips_pkg`: `REG_ID_W`=5, `DATA_W`=32, `REG_COUNT`=32, `ZERO_REG`=0.
- Sub-module `sync_fifo` (parameterised width and depth; push/pop/count, no bypass) holds `{md_reg_id, md_data}`.
- Arbiter, scoreboard and starvation counter live in the top module.

## Test plan
- Reset, then `wb_write`=1, id 5, data 0x1234 → `rf_write`=1, id 5, data 0x1234 one cycle later. Reset held → all outputs 0 and `md_ready`=0.
- `issue_md` id 8, then `rs_id`=8 → `stall`=1. MD push id 8 data 99 with WB idle → rf write (8, 99) next cycle, and `stall`=0 the cycle after.
- WB writes every cycle and one MD entry is queued → four WB grants, then `wb_stall`=1 and FIFO entry written. The held WB write lands the next cycle.
- Three MD pushes back-to-back with WB busy → `md_ready`=0 after two. The third is accepted only once a pop occurs; results are written in order.
- MD push with id 0 → no `rf_write`, FIFO drains, scoreboard unchanged. WB write to id 0 → no `rf_write`.
- Reset asserted with two FIFO entries and pending bits set → FIFO empty, `stall`=0, no stale writes afterwards.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared register-file constants and types for the decode-stage write scheduler.
package mips_pkg;
  localparam int REG_ID_W  = 5;
  localparam int DATA_W    = 32;
  localparam int REG_COUNT = 32;
  localparam logic [REG_ID_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ID_W-1:0] reg_id;
    logic [DATA_W-1:0]   data;
  } md_entry_t;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_WB   = 2'd1,
    GRANT_FIFO = 2'd2
  } grant_e;

  function automatic logic [REG_COUNT-1:0] reg_onehot(input logic [REG_ID_W-1:0] id);
    logic [REG_COUNT-1:0] mask;
    mask     = '0;
    mask[id] = 1'b1;
    return mask;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; a pushed entry is visible at the head one cycle later.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign push_ok_s = push & (count_r != CW'(DEPTH));
  assign pop_ok_s  = pop & (count_r != CW'(0));
  assign rd_data   = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge clock) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= wr_data;
  end
endmodule

// File: rtl/regwrite_scheduler.sv
// Arbitrates the register-file write port between WB and buffered MD results,
// tracking pending MD destinations to stall decode on hazards.
module regwrite_scheduler
  import mips_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wb_write,
  input  logic [REG_ID_W-1:0] wb_reg_id,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                md_valid,
  output logic                md_ready,
  input  logic [REG_ID_W-1:0] md_reg_id,
  input  logic [DATA_W-1:0]   md_data,
  input  logic                issue_md,
  input  logic [REG_ID_W-1:0] issue_reg_id,
  input  logic [REG_ID_W-1:0] rs_id,
  input  logic [REG_ID_W-1:0] rt_id,
  input  logic [REG_ID_W-1:0] rd_id,
  output logic                stall,
  output logic                wb_stall,
  output logic                rf_write,
  output logic [REG_ID_W-1:0] rf_write_id,
  output logic [DATA_W-1:0]   rf_write_data
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  md_entry_t            push_entry_s;
  md_entry_t            head_s;
  logic [CW-1:0]        fifo_count_s;
  logic                 fifo_empty_s;
  logic                 push_s;
  grant_e               grant_s;
  logic [REG_COUNT-1:0] pending_r;
  logic [REG_COUNT-1:0] set_mask_s;
  logic [REG_COUNT-1:0] clr_mask_s;
  logic [SW-1:0]        starve_r;

  assign push_entry_s = '{reg_id: md_reg_id, data: md_data};
  assign fifo_empty_s = (fifo_count_s == CW'(0));
  assign md_ready     = ~reset & (fifo_count_s < CW'(FIFO_DEPTH));
  assign push_s       = md_valid & md_ready;
  assign wb_stall     = ~reset & (starve_r == SW'(STARVE_LIMIT));
  // pending_r[0] is never set, so register 0 can never stall decode.
  assign stall        = ~reset & (pending_r[rs_id] | pending_r[rt_id] | pending_r[rd_id]);

  sync_fifo #(
    .WIDTH ($bits(md_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_md_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push_s),
    .pop     (grant_s == GRANT_FIFO),
    .wr_data (push_entry_s),
    .rd_data (head_s),
    .count   (fifo_count_s)
  );

  // Write-port arbitration: a starved FIFO overrides WB, otherwise WB has priority.
  always_comb begin
    grant_s = GRANT_NONE;
    if (wb_stall) begin
      if (!fifo_empty_s) grant_s = GRANT_FIFO;
      else               grant_s = GRANT_NONE;
    end else if (wb_write) begin
      grant_s = GRANT_WB;
    end else if (!fifo_empty_s) begin
      grant_s = GRANT_FIFO;
    end else begin
      grant_s = GRANT_NONE;
    end
  end

  // Scoreboard set/clear masks for this cycle.
  always_comb begin
    set_mask_s = '0;
    clr_mask_s = '0;
    if (issue_md && (issue_reg_id != ZERO_REG)) set_mask_s = reg_onehot(issue_reg_id);
    else                                        set_mask_s = '0;
    if ((grant_s == GRANT_FIFO) && (head_s.reg_id != ZERO_REG)) clr_mask_s = reg_onehot(head_s.reg_id);
    else                                                         clr_mask_s = '0;
  end

  // Scoreboard and starvation counter state.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_r <= '0;
      starve_r  <= '0;
    end else begin
      pending_r <= (pending_r & ~clr_mask_s) | set_mask_s;
      if ((grant_s == GRANT_FIFO) || fifo_empty_s) starve_r <= '0;
      else if (grant_s == GRANT_WB)                starve_r <= starve_r + SW'(1);
      else                                         starve_r <= starve_r;
    end
  end

  // Registered drive of the register-file write port; id 0 writes are dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      rf_write      <= 1'b0;
      rf_write_id   <= '0;
      rf_write_data <= '0;
    end else begin
      case (grant_s)
        GRANT_WB: begin
          rf_write      <= (wb_reg_id != ZERO_REG);
          rf_write_id   <= wb_reg_id;
          rf_write_data <= wb_data;
        end
        GRANT_FIFO: begin
          rf_write      <= (head_s.reg_id != ZERO_REG);
          rf_write_id   <= head_s.reg_id;
          rf_write_data <= head_s.data;
        end
        default: rf_write <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_regwrite_scheduler.sv
// Directed bench for regwrite_scheduler with an in-order scoreboard of expected register-file writes.
module tb_regwrite_scheduler;
  logic        clock = 1'b0;
  logic        reset;
  logic        wb_write;
  logic [4:0]  wb_reg_id;
  logic [31:0] wb_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_reg_id;
  logic [31:0] md_data;
  logic        issue_md;
  logic [4:0]  issue_reg_id;
  logic [4:0]  rs_id;
  logic [4:0]  rt_id;
  logic [4:0]  rd_id;
  logic        stall;
  logic        wb_stall;
  logic        rf_write;
  logic [4:0]  rf_write_id;
  logic [31:0] rf_write_data;

  int          total_cnt = 0;
  int          pass_cnt  = 0;
  logic [36:0] exp_q [$];
  logic [36:0] mon_e;

  always #5 clock = ~clock;

  regwrite_scheduler #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .wb_write(wb_write), .wb_reg_id(wb_reg_id), .wb_data(wb_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_reg_id(md_reg_id), .md_data(md_data),
    .issue_md(issue_md), .issue_reg_id(issue_reg_id),
    .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
    .stall(stall), .wb_stall(wb_stall),
    .rf_write(rf_write), .rf_write_id(rf_write_id), .rf_write_data(rf_write_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Every register-file write must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (rf_write) begin
      check("wr_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("wr_id", 64'(rf_write_id), 64'(mon_e[36:32]));
        check("wr_data", 64'(rf_write_data), 64'(mon_e[31:0]));
      end
    end
  end

  initial begin
    logic acc;
    reset = 1'b1; wb_write = 1'b0; wb_reg_id = 5'd0; wb_data = 32'd0;
    md_valid = 1'b0; md_reg_id = 5'd0; md_data = 32'd0;
    issue_md = 1'b0; issue_reg_id = 5'd0; rs_id = 5'd0; rt_id = 5'd0; rd_id = 5'd0;
    tick(); tick();
    check("rst_rf_write", 64'(rf_write), 64'd0);
    check("rst_rf_id", 64'(rf_write_id), 64'd0);
    check("rst_rf_data", 64'(rf_write_data), 64'd0);
    check("rst_md_ready", 64'(md_ready), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_wb_stall", 64'(wb_stall), 64'd0);
    reset = 1'b0;
    tick();
    check("md_ready_after_rst", 64'(md_ready), 64'd1);

    // Plain WB write
    wb_write = 1'b1; wb_reg_id = 5'd5; wb_data = 32'h1234;
    exp_q.push_back({5'd5, 32'h1234});
    tick();
    wb_write = 1'b0;
    check("wb_rf_write", 64'(rf_write), 64'd1);
    check("wb_rf_id", 64'(rf_write_id), 64'd5);
    check("wb_rf_data", 64'(rf_write_data), 64'h1234);
    tick();
    check("wb_idle", 64'(rf_write), 64'd0);

    // Scoreboard hazard and uncontended MD write
    issue_md = 1'b1; issue_reg_id = 5'd8;
    tick();
    issue_md = 1'b0; rs_id = 5'd8;
    #1;
    check("raw_stall", 64'(stall), 64'd1);
    md_valid = 1'b1; md_reg_id = 5'd8; md_data = 32'd99;
    exp_q.push_back({5'd8, 32'd99});
    tick();
    md_valid = 1'b0;
    check("md_no_bypass", 64'(rf_write), 64'd0);
    check("stall_held", 64'(stall), 64'd1);
    tick();
    check("md_rf_write", 64'(rf_write), 64'd1);
    check("md_rf_id", 64'(rf_write_id), 64'd8);
    check("md_rf_data", 64'(rf_write_data), 64'd99);
    check("stall_cleared", 64'(stall), 64'd0);
    rs_id = 5'd0;

    // Starvation: four WB grants with FIFO occupied, then the FIFO is forced
    wb_write = 1'b1; wb_reg_id = 5'd10;
    for (int k = 0; k < 5; k++) begin
      wb_data = 32'hA000 + 32'(k);
      md_valid = (k == 0); md_reg_id = 5'd11; md_data = 32'hB;
      exp_q.push_back({5'd10, 32'hA000 + 32'(k)});
      tick();
      check("wb_stall_seq", 64'(wb_stall), 64'(k == 4));
    end
    md_valid = 1'b0;
    wb_data = 32'hA005;
    exp_q.push_back({5'd11, 32'hB});
    exp_q.push_back({5'd10, 32'hA005});
    tick();
    check("forced_fifo_id", 64'(rf_write_id), 64'd11);
    check("wb_stall_cleared", 64'(wb_stall), 64'd0);
    tick();
    check("held_wb_id", 64'(rf_write_id), 64'd10);
    check("held_wb_data", 64'(rf_write_data), 64'hA005);
    wb_write = 1'b0;
    tick();

    // Backpressure: WB busy writing id 0 (dropped), three MD pushes
    wb_write = 1'b1; wb_reg_id = 5'd0; wb_data = 32'hDEAD;
    md_valid = 1'b1; md_reg_id = 5'd12; md_data = 32'hC1;
    exp_q.push_back({5'd12, 32'hC1});
    tick();
    md_reg_id = 5'd13; md_data = 32'hC2;
    exp_q.push_back({5'd13, 32'hC2});
    tick();
    check("md_ready_full", 64'(md_ready), 64'd0);
    check("wb_zero_dropped", 64'(rf_write), 64'd0);
    md_reg_id = 5'd14; md_data = 32'hC3;
    exp_q.push_back({5'd14, 32'hC3});
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = md_ready;
      tick();
    end
    md_valid = 1'b0;
    check("third_push_accepted", 64'(acc), 64'd1);
    wb_write = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("backpressure_drained", 64'(exp_q.size()), 64'd0);
    tick();

    // MD result to id 0 leaves the scoreboard alone; WB to id 0 writes nothing
    issue_md = 1'b1; issue_reg_id = 5'd20;
    tick();
    issue_md = 1'b0; rs_id = 5'd20;
    md_valid = 1'b1; md_reg_id = 5'd0; md_data = 32'h77;
    tick();
    md_valid = 1'b0;
    tick();
    check("md_zero_no_write", 64'(rf_write), 64'd0);
    check("md_zero_keeps_pending", 64'(stall), 64'd1);
    md_valid = 1'b1; md_reg_id = 5'd20; md_data = 32'h55;
    exp_q.push_back({5'd20, 32'h55});
    tick();
    md_valid = 1'b0;
    tick();
    check("after_zero_id", 64'(rf_write_id), 64'd20);
    check("after_zero_stall", 64'(stall), 64'd0);
    rs_id = 5'd0;
    wb_write = 1'b1; wb_reg_id = 5'd0; wb_data = 32'h99;
    tick();
    wb_write = 1'b0;
    check("wb_zero_no_write", 64'(rf_write), 64'd0);

    // Reset mid-operation discards buffered results and pending bits
    issue_md = 1'b1; issue_reg_id = 5'd21;
    tick();
    issue_reg_id = 5'd22;
    tick();
    issue_md = 1'b0;
    wb_write = 1'b1; wb_reg_id = 5'd0; wb_data = 32'h1;
    md_valid = 1'b1; md_reg_id = 5'd21; md_data = 32'hE1;
    tick();
    md_reg_id = 5'd22; md_data = 32'hE2;
    tick();
    md_valid = 1'b0; rt_id = 5'd21;
    #1;
    check("pre_rst_full", 64'(md_ready), 64'd0);
    check("pre_rst_stall", 64'(stall), 64'd1);
    reset = 1'b1; wb_write = 1'b0;
    tick();
    check("mid_rst_stall", 64'(stall), 64'd0);
    check("mid_rst_md_ready", 64'(md_ready), 64'd0);
    check("mid_rst_rf_write", 64'(rf_write), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_no_write", 64'(rf_write), 64'd0);
    end
    check("post_rst_stall", 64'(stall), 64'd0);
    check("post_rst_md_ready", 64'(md_ready), 64'd1);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
